legv8_regfile_sb: RTL and testbench

- 32 x 64-bit LEGv8 integer register file with a pending-write scoreboard.
- Sits directly downstream of the 5-bit register-select muxes: read_reg2 takes the selected Rm/Rt field.
- read_data1/read_data2 feed the ALU-operand 64-bit muxes.
- The scoreboard tracks destinations of in-flight instructions and raises a stall for decode when a source is still pending.

---
 rtl/legv8_regfile_sb.sv | 97 +++++++++
 tb/tb_legv8_regfile_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/legv8_regfile_sb.sv
// LEGv8 32 x 64-bit integer register file with write-through bypass, a
// pending-write scoreboard that stalls decode on RAW hazards, and a debug read port.
module legv8_regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              use1,
  input  logic              use2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              stall,
  output logic [5:0]        pending_count,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending_reg, pending_next;
  logic [NREG-1:0]   set_vec, clr_vec, rise_vec, fall_vec, zero_mask;
  logic [5:0]        count_reg, count_next;
  logic              hazard1, hazard2;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_real
        logic [DATA_W-1:0] value_reg;
        always_ff @(posedge clk or posedge reset) begin
          if (reset)
            value_reg <= '0;
          else if (reg_write && write_reg == ADDR_W'(gi))
            value_reg <= write_data;
        end
        assign regs[gi] = value_reg;
      end
    end
  endgenerate

  // Zero register reads as 0, a same-cycle writeback is forwarded, otherwise storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                   input logic              we,
                                                   input logic [ADDR_W-1:0] wa,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [DATA_W-1:0] stored);
    if (a == ZADDR)
      return '0;
    else if (we && wa == a)
      return wd;
    else
      return stored;
  endfunction

  assign read_data1 = read_port(read_reg1, reg_write, write_reg, write_data, regs[read_reg1]);
  assign read_data2 = read_port(read_reg2, reg_write, write_reg, write_data, regs[read_reg2]);

  // A new producer supersedes a retiring one on the same register.
  assign zero_mask    = ~(NREG'(1) << ZERO_REG);
  assign set_vec      = (issue_valid ? (NREG'(1) << issue_reg) : '0) & zero_mask;
  assign clr_vec      = reg_write ? (NREG'(1) << write_reg) : '0;
  assign rise_vec     = set_vec & ~pending_reg;
  assign fall_vec     = clr_vec & ~set_vec & pending_reg;
  assign pending_next = ((pending_reg | set_vec) & ~(clr_vec & ~set_vec)) & zero_mask;
  assign count_next   = count_reg + {5'd0, |rise_vec} - {5'd0, |fall_vec};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
      count_reg   <= '0;
      dbg_data    <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
      dbg_data    <= read_port(dbg_addr, reg_write, write_reg, write_data, regs[dbg_addr]);
    end
  end

  assign hazard1 = use1 && pending_reg[read_reg1] && !(reg_write && write_reg == read_reg1);
  assign hazard2 = use2 && pending_reg[read_reg2] && !(reg_write && write_reg == read_reg2);
  assign stall         = hazard1 || hazard2;
  assign pending_count = count_reg;

endmodule

// File: tb/tb_legv8_regfile_sb.sv
// Directed-vector bench for legv8_regfile_sb: bypass, zero register, scoreboard
// counting, stall generation, debug port and asynchronous reset.
module tb_legv8_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg, issue_reg, dbg_addr;
  logic        use1, use2, reg_write, issue_valid;
  logic [63:0] read_data1, read_data2, write_data, dbg_data;
  logic        stall;
  logic [5:0]  pending_count;

  int vec_count = 0;
  int err_count = 0;

  legv8_regfile_sb dut (
    .clk(clk), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .use1(use1), .use2(use2),
    .read_data1(read_data1), .read_data2(read_data2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .stall(stall), .pending_count(pending_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    read_reg1 = '0; read_reg2 = '0; use1 = 0; use2 = 0;
    reg_write = 0; write_reg = '0; write_data = '0;
    issue_valid = 0; issue_reg = '0; dbg_addr = '0;
    #12;
    check_vec("reset_rd1", read_data1, 64'd0);
    check_vec("reset_cnt", {58'd0, pending_count}, 64'd0);
    check_vec("reset_dbg", dbg_data, 64'd0);
    check_vec("reset_stall", {63'd0, stall}, 64'd0);
    reset = 1'b0;

    // Write X5, read it back, then async reset clears it mid-cycle
    tick();
    reg_write = 1; write_reg = 5; write_data = 64'h0123456789ABCDEF; read_reg1 = 5;
    tick();
    reg_write = 0;
    #1 check_vec("x5_read", read_data1, 64'h0123456789ABCDEF);
    #1 reset = 1'b1;
    #1 check_vec("x5_async_reset", read_data1, 64'd0);
    #1 reset = 1'b0;

    // Zero register: writes ignored, no bypass, no scoreboard entry
    tick();
    reg_write = 1; write_reg = 31; write_data = '1; read_reg2 = 31;
    issue_valid = 1; issue_reg = 31;
    #1 check_vec("x31_nobypass", read_data2, 64'd0);
    tick();
    reg_write = 0; issue_valid = 0;
    #1 check_vec("x31_read", read_data2, 64'd0);
    check_vec("x31_cnt", {58'd0, pending_count}, 64'd0);

    // Same-cycle bypass on both ports
    reg_write = 1; write_reg = 7; write_data = 64'hAA; read_reg1 = 7; read_reg2 = 7;
    #1 check_vec("byp_rd1", read_data1, 64'hAA);
    check_vec("byp_rd2", read_data2, 64'hAA);
    tick();
    reg_write = 0;
    #1 check_vec("x7_stored", read_data1, 64'hAA);

    // Issue X3 then hazard, use gating and bypass-resolved writeback
    issue_valid = 1; issue_reg = 3;
    tick();
    issue_valid = 0; use1 = 1; read_reg1 = 3;
    #1 check_vec("x3_stall", {63'd0, stall}, 64'd1);
    check_vec("x3_cnt", {58'd0, pending_count}, 64'd1);
    use1 = 0;
    #1 check_vec("x3_nouse", {63'd0, stall}, 64'd0);
    use1 = 1; reg_write = 1; write_reg = 3; write_data = 64'h33;
    #1 check_vec("x3_wb_stall", {63'd0, stall}, 64'd0);
    check_vec("x3_wb_data", read_data1, 64'h33);
    tick();
    reg_write = 0; use1 = 0;
    #1 check_vec("x3_cnt_clr", {58'd0, pending_count}, 64'd0);

    // Issue and writeback of X4 in the same cycle keeps it pending
    issue_valid = 1; issue_reg = 4;
    tick();
    check_vec("x4_cnt", {58'd0, pending_count}, 64'd1);
    issue_reg = 4; reg_write = 1; write_reg = 4; write_data = 64'h44;
    tick();
    issue_valid = 0; reg_write = 0;
    use1 = 1; read_reg1 = 4;
    #1 check_vec("x4_cnt_same", {58'd0, pending_count}, 64'd1);
    check_vec("x4_still_pend", {63'd0, stall}, 64'd1);
    use1 = 0;

    // X9 pending; issue X8 while X9 retires -> net count unchanged
    issue_valid = 1; issue_reg = 9;
    tick();
    check_vec("x9_cnt", {58'd0, pending_count}, 64'd2);
    issue_reg = 8; reg_write = 1; write_reg = 9; write_data = 64'h99;
    tick();
    issue_valid = 0; reg_write = 0;
    #1 check_vec("x8x9_cnt", {58'd0, pending_count}, 64'd2);
    use2 = 1; read_reg2 = 8;
    #1 check_vec("x8_pend", {63'd0, stall}, 64'd1);
    read_reg2 = 9;
    #1 check_vec("x9_clear", {63'd0, stall}, 64'd0);
    use2 = 0;

    // Issue X1..X30 back to back (X4 and X8 already pending)
    for (int r = 1; r <= 30; r++) begin
      issue_valid = 1; issue_reg = 5'(r);
      tick();
    end
    issue_valid = 0;
    check_vec("all_cnt", {58'd0, pending_count}, 64'd30);

    // Write X12 = 0x55, then debug read it with one cycle latency
    reg_write = 1; write_reg = 12; write_data = 64'h55;
    tick();
    reg_write = 0; dbg_addr = 12;
    check_vec("x12_cnt", {58'd0, pending_count}, 64'd29);
    tick();
    check_vec("dbg_x12", dbg_data, 64'h55);

    // Debug bypass and zero register
    reg_write = 1; write_reg = 20; write_data = 64'h2020; dbg_addr = 20;
    tick();
    reg_write = 0; dbg_addr = 31;
    check_vec("dbg_bypass", dbg_data, 64'h2020);
    tick();
    check_vec("dbg_x31", dbg_data, 64'd0);

    // Reset asserted during a writeback discards it
    reg_write = 1; write_reg = 10; write_data = 64'h1010; read_reg1 = 10;
    #1 reset = 1'b1;
    tick();
    reg_write = 0; reset = 1'b0;
    #1 check_vec("wb_discard", read_data1, 64'd0);
    check_vec("post_reset_cnt", {58'd0, pending_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
